mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port word memory between the core's instruction-fetch port (I) and load/store port (D).
- Memory contract it drives:
  - mem_rw high = read, low = write; the memory acts on every posedge.
  - Read data appears on mem_rdata the cycle after the memory samples the address.
  - mem_addr is a byte address; the memory drops bits [1:0].
- Arbiter registers all memory-side controls, serialises transactions, and routes read data back to the winning port.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of a single-port word memory.
// Optional build macro MEM_ARB_RR_EN: round-robin on conflict instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              mem_rw_reg, mem_rw_next;
  logic              d_wins;

`ifdef MEM_ARB_RR_EN
  logic rr_last_reg, rr_last_next;
  // On conflict the port that was not granted most recently wins.
  assign d_wins = d_req && (!i_req || (rr_last_reg == PORT_I));
`else
  assign d_wins = d_req;
`endif

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_rw_next    = mem_rw_reg;
`ifdef MEM_ARB_RR_EN
    rr_last_next   = rr_last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          state_next = ACCESS;
          if (d_wins) begin
            owner_next     = PORT_D;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            mem_rw_next    = ~d_we;
          end else begin
            owner_next     = PORT_I;
            mem_addr_next  = i_addr;
            mem_rw_next    = 1'b1;
          end
`ifdef MEM_ARB_RR_EN
          rr_last_next = d_wins ? PORT_D : PORT_I;
`endif
        end
      end
      ACCESS: begin
        // The memory commits the access at the closing edge; fall back to read-only.
        mem_rw_next = 1'b1;
        state_next  = mem_rw_reg ? RESP : IDLE;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      owner_reg     <= PORT_I;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_rw_reg    <= 1'b1;
`ifdef MEM_ARB_RR_EN
      rr_last_reg   <= PORT_D;
`endif
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_rw_reg    <= mem_rw_next;
`ifdef MEM_ARB_RR_EN
      rr_last_reg   <= rr_last_next;
`endif
    end
  end

  // Per-port response path: index 0 = I, index 1 = D.
  logic [1:0]             gnt_vec;
  logic [1:0]             rvalid_vec;
  logic [1:0][DATA_W-1:0] rdata_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_hold_reg;

    assign gnt_vec[gi]    = (state_reg == ACCESS) && (owner_reg == 1'(gi));
    assign rvalid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : rdata_hold_reg;

    // Non-owner data keeps showing the last word delivered to that port.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rdata_hold_reg <= '0;
      end else if (rvalid_vec[gi]) begin
        rdata_hold_reg <= mem_rdata;
      end
    end
  end

  assign i_gnt     = gnt_vec[0];
  assign d_gnt     = gnt_vec[1];
  assign i_rvalid  = rvalid_vec[0];
  assign d_rvalid  = rvalid_vec[1];
  assign i_rdata   = rdata_vec[0];
  assign d_rdata   = rdata_vec[1];
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_rw    = mem_rw_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-accurate vector table plus hand-written
// sequences for reset, idle safety, held conflicts and reset during an access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_rw;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    case (k)
      0:       return 32'h0010_0313;
      1:       return 32'h0010_0393;
      2:       return 32'h0000_0e13;
      default: return 32'hA5A5_0000 | 32'(k);
    endcase
  endfunction

  // Word memory model: write when mem_rw low, registered read data.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
    end else if (mem_rw == 1'b0) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[6:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  // ctl bits: {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_rw}
  localparam logic [4:0] IG = 5'b10000, DG = 5'b01000, IV = 5'b00100, DV = 5'b00010, RW = 5'b00001;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [4:0]  ctl;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input logic [4:0] ctl, input logic [31:0] rdata);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ctl = ctl; v.rdata = rdata;
    return v;
  endfunction

  vec_t tbl [15];

  function automatic logic [4:0] ctl_now();
    return {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_rw};
  endfunction

  initial begin
    logic [31:0] exp_i_hold, exp_d_hold;
    logic        i_seen, d_seen;
    logic        prev_port, have_prev;
    int          n_grants;

    // Store then load, single fetch, then D/I conflict (each entry = one cycle).
    tbl[0]  = mk(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, RW,      0);
    tbl[1]  = mk(0, 0, 1, 0, 32'h40, 0,            DG,      0);
    tbl[2]  = mk(0, 0, 1, 0, 32'h40, 0,            RW,      0);
    tbl[3]  = mk(0, 0, 0, 0, 0,      0,            DG | RW, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,      0,            DV | RW, 32'hDEADBEEF);
    tbl[5]  = mk(1, 4, 0, 0, 0,      0,            RW,      0);
    tbl[6]  = mk(0, 0, 0, 0, 0,      0,            IG | RW, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,      0,            IV | RW, 32'h0010_0393);
    tbl[8]  = mk(1, 8, 1, 0, 0,      0,            RW,      0);
    tbl[9]  = mk(1, 8, 0, 0, 0,      0,            DG | RW, 0);
    tbl[10] = mk(1, 8, 0, 0, 0,      0,            DV | RW, 32'h0010_0313);
    tbl[11] = mk(1, 8, 0, 0, 0,      0,            RW,      0);
    tbl[12] = mk(0, 0, 0, 0, 0,      0,            IG | RW, 0);
    tbl[13] = mk(0, 0, 0, 0, 0,      0,            IV | RW, 32'h0000_0e13);
    tbl[14] = mk(0, 0, 0, 0, 0,      0,            RW,      0);

    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 64'(ctl_now()), 64'(RW));
    check("reset_mem_addr", 64'(mem_addr), 64'(0));
    check("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    next_cycle();
    resetn = 1'b1;

    // Idle safety: nothing requested, memory must never be written.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle_ctl_c%0d", c), 64'(ctl_now()), 64'(RW));
      next_cycle();
    end
    for (int k = 0; k <= 8; k++)
      check($sformatf("idle_mem%0d", k), 64'(mem[k]), 64'(init_word(k)));

    // Table-driven cycle-accurate vectors.
    i_seen = 1'b0; d_seen = 1'b0; exp_i_hold = '0; exp_d_hold = '0;
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].dd);
      @(negedge clk);
      check($sformatf("vec%0d_ctl", k), 64'(ctl_now()), 64'(tbl[k].ctl));
      if ((tbl[k].ctl & IV) != 0) begin
        exp_i_hold = tbl[k].rdata; i_seen = 1'b1;
      end
      if ((tbl[k].ctl & DV) != 0) begin
        exp_d_hold = tbl[k].rdata; d_seen = 1'b1;
      end
      if (i_seen) check($sformatf("vec%0d_i_rdata", k), 64'(i_rdata), 64'(exp_i_hold));
      if (d_seen) check($sformatf("vec%0d_d_rdata", k), 64'(d_rdata), 64'(exp_d_hold));
      next_cycle();
    end

    // Both ports hold read requests for 12 cycles.
    drive(1, 8, 1, 0, 0, 0);
    have_prev = 1'b0; prev_port = 1'b0; n_grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("hold_c%0d_one_gnt", c), 64'(i_gnt & d_gnt), 64'(0));
      if (i_gnt || d_gnt) begin
        n_grants++;
`ifdef MEM_ARB_RR_EN
        if (have_prev)
          check($sformatf("hold_c%0d_alternate", c), 64'(d_gnt == prev_port), 64'(0));
        else
          check("hold_first_is_d", 64'(d_gnt), 64'(1));
`else
        check($sformatf("hold_c%0d_d_wins", c), 64'(d_gnt), 64'(1));
`endif
        have_prev = 1'b1;
        prev_port = d_gnt;
      end
      next_cycle();
    end
    check("hold_grant_count", 64'(n_grants), 64'(4));
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) next_cycle();

    // Reset asserted while an I read is in ACCESS.
    drive(1, 4, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_mid_idle_ctl", 64'(ctl_now()), 64'(RW));
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_access_gnt", 64'(ctl_now()), 64'(IG | RW));
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_after_ctl", 64'(ctl_now()), 64'(RW));
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("rst_mid_quiet_c%0d", c), 64'(ctl_now()), 64'(RW));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
